// File: rtl/cache_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter_pkg
// Shared definitions for the I/D cache memory arbiter:
//   - state_t  : arbiter FSM states
//   - owner_t  : transaction owner encoding (OWN_I = 0, OWN_D = 1)
//   - DEF_BLK_WORDS / DEF_MEM_LAT : default block size and memory latency
//   - store_addr() : word-aligns a byte address for a single-word store
// -----------------------------------------------------------------------------
package cache_mem_arbiter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_DRAIN = 3'd2,
      ST_STORE = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

   localparam int DEF_BLK_WORDS = 8;
   localparam int DEF_MEM_LAT   = 4;

   // Memory is 16-bit word addressed through byte addresses: bit 0 is dropped.
   function automatic logic [15:0] store_addr(input logic [15:0] addr);
      return {addr[15:1], 1'b0};
   endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter_if
// Memory-side bus shared by the arbiter (master) and the memory (slave).
//   mem_en    : access strobe, one word per cycle      (master -> slave)
//   mem_wr    : write qualifier                         (master -> slave)
//   mem_addr  : byte address                            (master -> slave)
//   mem_wdata : write data                              (master -> slave)
//   mem_rdata : read data                               (slave -> master)
//   mem_valid : mem_rdata valid, MEM_LAT after mem_en   (slave -> master)
// -----------------------------------------------------------------------------
interface cache_mem_arbiter_if;

   logic        mem_en;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_valid;

   modport master (
      output mem_en, mem_wr, mem_addr, mem_wdata,
      input  mem_rdata, mem_valid
   );

   modport slave (
      input  mem_en, mem_wr, mem_addr, mem_wdata,
      output mem_rdata, mem_valid
   );

endinterface

// File: rtl/cache_mem_arbiter_arb_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
// Combinational two-requester grant used by the arbiter FSM while idle.
//   i_req, d_req : pending requests
//   last_owner   : owner served last (only with ARB_ROUND_ROBIN_EN)
//   grant_valid  : at least one request pending
//   grant_owner  : selected owner
// Build option ARB_ROUND_ROBIN_EN: on a tie grant the side not served last;
// otherwise D always wins a tie.
// -----------------------------------------------------------------------------
module arb_pick
   import cache_mem_arbiter_pkg::*;
(
   input  logic   i_req,
   input  logic   d_req,
`ifdef ARB_ROUND_ROBIN_EN
   input  owner_t last_owner,
`endif
   output logic   grant_valid,
   output owner_t grant_owner
);

   // Tie-break between the two requesters.
   always_comb begin
      grant_valid = i_req | d_req;
      grant_owner = OWN_I;
      if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
         grant_owner = (last_owner == OWN_D) ? OWN_I : OWN_D;
`else
         grant_owner = OWN_D;
`endif
      end else if (d_req) begin
         grant_owner = OWN_D;
      end else begin
         grant_owner = OWN_I;
      end
   end

endmodule

// File: rtl/cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter
// Arbitrates I-cache fills and D-cache fills/stores onto one memory port.
// Fills issue BLK_WORDS consecutive reads and forward each return to the
// owning cache; stores issue one write. Completion is a one-cycle done pulse.
//   clk, rst          : clock, asynchronous active-high reset
//   i_req, i_addr     : I-cache fill request (level) and byte address
//   d_req, d_wr       : D-cache request (level); d_wr=1 store, 0 fill
//   d_addr, d_wdata   : D-cache byte address and store data
//   mem               : memory bus (cache_mem_arbiter_if.master)
//   fill_we/sel/word/data : fill write port towards the caches
//   i_done, d_done    : completion pulses
//   busy              : any state but IDLE
// Build option ARB_ROUND_ROBIN_EN: round-robin tie-break with a last-owner
// flop (reset to I so D wins the first tie); default is fixed D-over-I.
// -----------------------------------------------------------------------------
module cache_mem_arbiter
   import cache_mem_arbiter_pkg::*;
#(
   parameter int BLK_WORDS = DEF_BLK_WORDS,
   parameter int MEM_LAT   = DEF_MEM_LAT
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_req,
   input  logic [15:0]                   i_addr,
   input  logic                          d_req,
   input  logic                          d_wr,
   input  logic [15:0]                   d_addr,
   input  logic [15:0]                   d_wdata,
   cache_mem_arbiter_if.master           mem,
   output logic                          fill_we,
   output logic                          fill_sel,
   output logic [$clog2(BLK_WORDS)-1:0]  fill_word,
   output logic [15:0]                   fill_data,
   output logic                          i_done,
   output logic                          d_done,
   output logic                          busy
);

   localparam int W = $clog2(BLK_WORDS);
   localparam logic [W-1:0] LAST_WORD = W'(BLK_WORDS - 1);

   if (BLK_WORDS < 2 || BLK_WORDS > 16 || (BLK_WORDS & (BLK_WORDS - 1)) != 0 || MEM_LAT < 1) begin : g_param_check
      $error("cache_mem_arbiter: illegal BLK_WORDS or MEM_LAT");
   end

   // Word k of the block containing base: {base[15:W+1], k, 1'b0}.
   function automatic logic [15:0] fill_addr(input logic [15:0] base, input logic [W-1:0] k);
      logic [15:0] a;
      a        = base;
      a[W:1]   = k;
      a[0]     = 1'b0;
      return a;
   endfunction

   state_t         state_r;
   state_t         state_next_s;
   owner_t         owner_r;
   logic           wr_r;
   logic [15:0]    addr_r;
   logic [15:0]    wdata_r;
   logic [W-1:0]   iss_cnt_r;
   logic [W-1:0]   rx_cnt_r;
   logic           rx_full_r;

   logic           grant_valid_s;
   owner_t         grant_owner_s;
   logic           rx_fire_s;
   logic           rx_last_s;
   logic           iss_last_s;

`ifdef ARB_ROUND_ROBIN_EN
   owner_t         last_owner_r;
`endif

   arb_pick u_arb_pick (
      .i_req       (i_req),
      .d_req       (d_req),
`ifdef ARB_ROUND_ROBIN_EN
      .last_owner  (last_owner_r),
`endif
      .grant_valid (grant_valid_s),
      .grant_owner (grant_owner_s)
   );

   // A return is accepted only while a fill is outstanding; rx_full_r blocks
   // any surplus return that might arrive before the issue phase ends.
   assign rx_fire_s  = mem.mem_valid && !rx_full_r &&
                       (state_r == ST_ISSUE || state_r == ST_DRAIN);
   assign rx_last_s  = rx_fire_s && (rx_cnt_r == LAST_WORD);
   assign iss_last_s = (state_r == ST_ISSUE) && (iss_cnt_r == LAST_WORD);

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (grant_valid_s) begin
               state_next_s = (grant_owner_s == OWN_D && d_wr) ? ST_STORE : ST_ISSUE;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (iss_last_s) begin
               state_next_s = (rx_full_r || rx_last_s) ? ST_DONE : ST_DRAIN;
            end else begin
               state_next_s = ST_ISSUE;
            end
         end
         ST_DRAIN: begin
            if (rx_last_s) begin
               state_next_s = ST_DONE;
            end else begin
               state_next_s = ST_DRAIN;
            end
         end
         ST_STORE: state_next_s = ST_DONE;
         ST_DONE:  state_next_s = ST_IDLE;
         default:  state_next_s = ST_IDLE;
      endcase
   end

   // Transaction context and issue/receive counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_r   <= OWN_I;
         wr_r      <= 1'b0;
         addr_r    <= 16'h0000;
         wdata_r   <= 16'h0000;
         iss_cnt_r <= '0;
         rx_cnt_r  <= '0;
         rx_full_r <= 1'b0;
      end else if (state_r == ST_IDLE) begin
         if (grant_valid_s) begin
            owner_r   <= grant_owner_s;
            wr_r      <= (grant_owner_s == OWN_D) && d_wr;
            addr_r    <= (grant_owner_s == OWN_D) ? d_addr : i_addr;
            wdata_r   <= d_wdata;
            iss_cnt_r <= '0;
            rx_cnt_r  <= '0;
            rx_full_r <= 1'b0;
         end
      end else begin
         // Both counters wrap naturally because BLK_WORDS is a power of two.
         if (state_r == ST_ISSUE) begin
            iss_cnt_r <= iss_cnt_r + W'(1);
         end
         if (rx_fire_s) begin
            rx_cnt_r <= rx_cnt_r + W'(1);
         end
         if (rx_last_s) begin
            rx_full_r <= 1'b1;
         end
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   // Remembers the side granted last for the round-robin tie-break.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_owner_r <= OWN_I;
      end else if (state_r == ST_IDLE && grant_valid_s) begin
         last_owner_r <= grant_owner_s;
      end
   end
`endif

   // FSM output decode: everything derives from state, counters and context.
   always_comb begin
      mem.mem_en    = 1'b0;
      mem.mem_wr    = 1'b0;
      mem.mem_addr  = 16'h0000;
      mem.mem_wdata = 16'h0000;
      case (state_r)
         ST_ISSUE: begin
            mem.mem_en   = 1'b1;
            mem.mem_addr = fill_addr(addr_r, iss_cnt_r);
         end
         ST_STORE: begin
            mem.mem_en    = 1'b1;
            mem.mem_wr    = wr_r;
            mem.mem_addr  = store_addr(addr_r);
            mem.mem_wdata = wdata_r;
         end
         default: begin
            mem.mem_en    = 1'b0;
         end
      endcase
      fill_we   = rx_fire_s;
      fill_sel  = rx_fire_s && (owner_r == OWN_D);
      fill_word = rx_cnt_r;
      i_done    = (state_r == ST_DONE) && (owner_r == OWN_I);
      d_done    = (state_r == ST_DONE) && (owner_r == OWN_D);
      busy      = (state_r != ST_IDLE);
   end

   // Read data passes straight through; forced low while reset is applied.
   assign fill_data = rst ? 16'h0000 : mem.mem_rdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
`timescale 1ns/1ps
module tb_cache_mem_arbiter;
   import cache_mem_arbiter_pkg::*;

   localparam int BW  = 8;
   localparam int LAT = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
   logic [15:0] i_addr = 16'h0, d_addr = 16'h0, d_wdata = 16'h0;
   logic        fill_we, fill_sel, i_done, d_done, busy;
   logic [2:0]  fill_word;
   logic [15:0] fill_data;
   logic        spur = 1'b0;

   always #5 clk = ~clk;

   cache_mem_arbiter_if mem_if();

   cache_mem_arbiter #(.BLK_WORDS(BW), .MEM_LAT(LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .d_req     (d_req),
      .d_wr      (d_wr),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .mem       (mem_if.master),
      .fill_we   (fill_we),
      .fill_sel  (fill_sel),
      .fill_word (fill_word),
      .fill_data (fill_data),
      .i_done    (i_done),
      .d_done    (d_done),
      .busy      (busy)
   );

   // Memory model: a read issued in cycle n returns in cycle n+LAT with
   // data = address ^ 16'h5A5A.
   logic [LAT-1:0] pv_r = '0;
   logic [15:0]    pa_r [LAT] = '{default: 16'h0000};

   always @(posedge clk) begin
      pv_r    <= {pv_r[LAT-2:0], mem_if.mem_en & ~mem_if.mem_wr};
      pa_r[0] <= mem_if.mem_addr;
      for (int i = 1; i < LAT; i++) pa_r[i] <= pa_r[i-1];
   end

   assign mem_if.mem_valid = pv_r[LAT-1] | spur;
   assign mem_if.mem_rdata = pa_r[LAT-1] ^ 16'h5A5A;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return {6'd0, mem_if.mem_en, mem_if.mem_wr, mem_if.mem_addr, mem_if.mem_wdata,
              fill_we, fill_sel, fill_word, fill_data, i_done, d_done, busy};
   endfunction

   // kind: 0 = I fill, 1 = D fill, 2 = D store
   typedef struct {
      logic [1:0]  kind;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_addr;   // fill: word-0 address; store: store address
      logic        exp_sel;
      int          exp_done;
      int          exp_en;
      int          exp_we;
   } vec_t;

   vec_t vecs [6];

   task automatic run_vec(input vec_t v);
      int n_en = 0;
      int n_we = 0;
      int done_c = -1;
      logic [15:0] ea;
      @(negedge clk);
      if (v.kind == 2'd0) begin
         i_req = 1'b1; i_addr = v.addr;
      end else begin
         d_req = 1'b1; d_wr = (v.kind == 2'd2); d_addr = v.addr; d_wdata = v.wdata;
      end
      for (int c = 1; c <= 40 && done_c < 0; c++) begin
         @(negedge clk);
         if (c == 1) check("busy_after_grant", 64'(busy), 64'd1);
         if (mem_if.mem_en) begin
            check("mem_wr", 64'(mem_if.mem_wr), 64'(v.kind == 2'd2));
            ea = (v.kind == 2'd2) ? v.exp_addr : v.exp_addr + 16'(2 * n_en);
            check("mem_addr", 64'(mem_if.mem_addr), 64'(ea));
            if (v.kind == 2'd2) check("mem_wdata", 64'(mem_if.mem_wdata), 64'(v.wdata));
            n_en++;
         end
         if (fill_we) begin
            check("fill_word", 64'(fill_word), 64'(n_we));
            check("fill_sel", 64'(fill_sel), 64'(v.exp_sel));
            ea = (v.exp_addr + 16'(2 * n_we)) ^ 16'h5A5A;
            check("fill_data", 64'(fill_data), 64'(ea));
            n_we++;
         end
         if (i_done || d_done) begin
            done_c = c;
            check("done_owner", 64'({i_done, d_done}), (v.kind == 2'd0) ? 64'd2 : 64'd1);
            i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
         end
      end
      check("done_cycle", 64'(done_c), 64'(v.exp_done));
      check("mem_en_count", 64'(n_en), 64'(v.exp_en));
      check("fill_we_count", 64'(n_we), 64'(v.exp_we));
      @(negedge clk);
      check("busy_idle_after", 64'(busy), 64'd0);
   endtask

   initial begin
      int   ic, dc, k, hit, bad;
      logic [3:0] order;
      vec_t rv;

      vecs[0] = '{2'd0, 16'h1234, 16'h0000, 16'h1230, 1'b0, 13, 8, 8};
      vecs[1] = '{2'd1, 16'hABCF, 16'h0000, 16'hABC0, 1'b1, 13, 8, 8};
      vecs[2] = '{2'd2, 16'h0041, 16'hBEEF, 16'h0040, 1'b0, 2, 1, 0};
      vecs[3] = '{2'd0, 16'hFFFF, 16'h0000, 16'hFFF0, 1'b0, 13, 8, 8};
      vecs[4] = '{2'd2, 16'h1235, 16'h1357, 16'h1234, 1'b0, 2, 1, 0};
      vecs[5] = '{2'd0, 16'h000E, 16'h0000, 16'h0000, 1'b0, 13, 8, 8};

      // Reset state.
      @(negedge clk);
      check("reset_outputs", all_outs(), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int v = 0; v < 6; v++) run_vec(vecs[v]);

      // Simultaneous requests, each requester drops on its own done.
      @(negedge clk);
      i_req = 1'b1; i_addr = 16'h0200;
      d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0300;
      ic = -1; dc = -1; hit = 0;
      for (int c = 1; c <= 60 && (ic < 0 || dc < 0); c++) begin
         @(negedge clk);
         if (fill_we && hit == 0) begin
            hit = 1;
            check("both_first_sel", 64'(fill_sel), 64'd1);
         end
         if (d_done) begin dc = c; d_req = 1'b0; end
         if (i_done) begin ic = c; i_req = 1'b0; end
      end
      check("both_d_done_cycle", 64'(dc), 64'd13);
      check("both_i_done_cycle", 64'(ic), 64'd27);

      // Both requests held across four transactions: service order.
      @(negedge clk);
      i_req = 1'b1; i_addr = 16'h0500;
      d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0600;
      k = 0; order = 4'd0;
      for (int c = 1; c <= 80 && k < 4; c++) begin
         @(negedge clk);
         if (i_done || d_done) begin
            order[k] = d_done;
            k++;
            if (k == 4) begin i_req = 1'b0; d_req = 1'b0; end
         end
      end
      check("held_done_count", 64'(k), 64'd4);
`ifdef ARB_ROUND_ROBIN_EN
      check("held_order", 64'(order), 64'b0101);
`else
      check("held_order", 64'(order), 64'b1111);
`endif
      @(negedge clk);

      // Reset on the third returned word.
      @(negedge clk);
      i_req = 1'b1; i_addr = 16'h1234;
      hit = 0;
      for (int c = 1; c <= 20 && hit == 0; c++) begin
         @(negedge clk);
         if (fill_we && fill_word == 3'd2) hit = c;
      end
      check("rst_word2_cycle", 64'(hit), 64'd7);
      rst = 1'b1; i_req = 1'b0;
      #1;
      check("rst_mid_outputs", all_outs(), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (fill_we || busy) bad++;
      end
      check("late_returns_dropped", 64'(bad), 64'd0);
      rv = '{2'd0, 16'h2000, 16'h0000, 16'h2000, 1'b0, 13, 8, 8};
      run_vec(rv);

      // Spurious returns while idle.
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         spur = 1'b1;
         #1;
         check("spur_idle_fill_we", 64'(fill_we), 64'd0);
      end
      @(negedge clk);
      spur = 1'b0;
      check("spur_idle_busy", 64'(busy), 64'd0);

      // D store request rising during an I fill waits for i_done.
      @(negedge clk);
      i_req = 1'b1; i_addr = 16'h0400;
      ic = -1; dc = -1; bad = 0;
      for (int c = 1; c <= 40 && dc < 0; c++) begin
         @(negedge clk);
         if (c == 5) begin
            d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0100; d_wdata = 16'h55AA;
         end
         if (mem_if.mem_wr) begin
            if (ic < 0) bad++;
            check("late_store_addr", 64'(mem_if.mem_addr), 64'h0100);
            check("late_store_data", 64'(mem_if.mem_wdata), 64'h55AA);
         end
         if (i_done) begin ic = c; i_req = 1'b0; end
         if (d_done) begin dc = c; d_req = 1'b0; d_wr = 1'b0; end
      end
      check("late_i_done_cycle", 64'(ic), 64'd13);
      check("late_d_done_cycle", 64'(dc), 64'd16);
      check("store_before_i_done", 64'(bad), 64'd0);

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 Parameter BLK_WORDS, default 8, meaning 16-bit words per cache block (power of 2, 2..16).
REQ-002 Parameter MEM_LAT, default 4, meaning cycles from mem_en to matching mem_valid.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 i_req  input  1  I-cache miss fill request, level, held until i_done.
REQ-006 i_addr  input  16  I-miss byte address.
REQ-007 d_req  input  1  D-cache request (fill or store), level, held until d_done.
REQ-008 d_wr  input  1  with d_req: 1 = single-word store, 0 = block fill.
REQ-009 d_addr  input  16  D byte address.
REQ-010 d_wdata  input  16  store data.
REQ-011 mem_en  output  1  memory access strobe, one word per cycle.
REQ-012 mem_wr  output  1  memory write qualifier.
REQ-013 mem_addr  output  16  memory byte address.
REQ-014 mem_wdata  output  16  memory write data.
REQ-015 mem_rdata  input  16  read data.
REQ-016 mem_valid  input  1  mem_rdata valid.
REQ-017 fill_we  output  1  fill word write strobe to selected cache.
REQ-018 fill_sel  output  1  0 = I-cache, 1 = D-cache.
REQ-019 fill_word  output  log2(BLK_WORDS)  word offset of fill_data.
REQ-020 fill_data  output  16  equals mem_rdata.
REQ-021 i_done, d_done  output  1 each  single-cycle completion pulses.
REQ-022 busy  output  1  high in any state except IDLE.

Function
REQ-023 FSM states IDLE, ISSUE, DRAIN, STORE, DONE.
REQ-024 IDLE: d_req wins over i_req (default policy); no request keeps IDLE; grant latches owner, address, d_wr, d_wdata.
REQ-025 Fill grant -> ISSUE: mem_en=1, mem_wr=0 for exactly BLK_WORDS consecutive cycles, word k address = {addr[15:log2(BLK_WORDS)+1], k, 1'b0}, k = 0..BLK_WORDS-1.
REQ-026 After the last issue -> DRAIN until BLK_WORDS mem_valid received; returns may overlap ISSUE.
REQ-027 Each mem_valid during ISSUE/DRAIN: fill_we=1, fill_sel=owner, fill_word=receive counter, counter increments, wraps to 0 after BLK_WORDS-1.
REQ-028 Last return -> DONE; DONE pulses owner's done one cycle, then IDLE.
REQ-029 Store grant -> STORE: one cycle mem_en=1, mem_wr=1, mem_addr=d_addr with bit0 cleared, mem_wdata=d_wdata; then DONE.
REQ-030 New request sampled only in IDLE; request arriving mid-transaction waits; requester dropping req mid-transaction does not abort it.
REQ-031 mem_valid in IDLE, STORE or DONE ignored; extra returns beyond BLK_WORDS ignored.
REQ-032 Outputs are registered or decoded from state/counters only; no combinational path from i_req/d_req to mem_en.
REQ-033 Fill transaction total latency = BLK_WORDS + MEM_LAT + 1 cycles from grant to done pulse; store = 2 cycles.

Reset
REQ-034 rst asserted: state IDLE, counters 0, owner 0, all outputs 0, immediately, including mid-transaction; in-flight memory returns after release are dropped per REQ-031.

Configuration
REQ-035 ARB_ROUND_ROBIN_EN defined: when both requests pending in IDLE, grant the requester not served last (last-owner flop, reset to I so D wins first); undefined: fixed D-over-I priority, no last-owner flop.

Structure
REQ-036 Shared package holds FSM state enum, owner encoding (OWN_I=0, OWN_D=1) and default BLK_WORDS/MEM_LAT constants.
REQ-037 One sub-module arb_pick: combinational two-requester priority/round-robin grant, used by the FSM in IDLE.

Verification
REQ-038 Lone i_req, i_addr=0x1234: mem_addr 0x1230..0x123E step 2 over 8 cycles; 8 fill_we with fill_sel=0, fill_word 0..7; i_done at cycle 13.
REQ-039 i_req and d_req same cycle: D fill served first, i_done after d_done; with ARB_ROUND_ROBIN_EN, repeated both-pending alternates D,I,D,I.
REQ-040 d_req+d_wr, d_addr=0x0041, d_wdata=0xBEEF: one mem_wr cycle at 0x0040 data 0xBEEF; d_done 2 cycles after grant; no fill_we.
REQ-041 rst pulsed on 3rd returned word: outputs 0 that cycle; late mem_valid ignored; next i_req starts clean at word 0.
REQ-042 Spurious mem_valid in IDLE, and d_req rising during I fill: no fill_we in IDLE; D granted only after i_done.
